// File: rtl/aes_pkg.sv
// Shared AES-128 inverse-cipher constants, types and GF(2^8) byte transforms.
// Byte k of a block sits at [127-8k -: 8]; k = 4*column + row.
package aes_pkg;
  localparam int NR  = 10;
  localparam int RKW = 4;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;
  typedef logic [127:0]   block_t;
  typedef logic [RKW-1:0] rk_addr_t;

  localparam rk_addr_t RK_LAST = rk_addr_t'(NR);
  localparam rk_addr_t RK_NR1  = rk_addr_t'(NR - 1);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse affine map, then multiplicative inverse as x^254 (0 maps to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] x;
    logic [7:0] s;
    logic [7:0] p;
    x = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    s = x;
    p = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      p = gmul(p, s);
    end
    return p;
  endfunction

  function automatic block_t inv_shift_rows(input block_t s);
    block_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic block_t inv_sub_bytes(input block_t s);
    block_t o;
    o = '0;
    for (int k = 0; k < 16; k++)
      o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic block_t inv_mix_columns(input block_t s);
    block_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction
endpackage

// File: rtl/aes_inv_cipher_ctrl_if.sv
// Block-in / block-out handshake plus round-key fetch bus of the inverse cipher.
// slave = sequencer side, master = environment (source, sink, key store).
interface aes_inv_cipher_ctrl_if;
  import aes_pkg::*;

  logic     in_valid;
  logic     in_ready;
  block_t   in_data;
  logic     abort;
  rk_addr_t rk_addr;
  block_t   rk_data;
  logic     out_valid;
  logic     out_ready;
  block_t   out_data;
  logic     busy;

  modport slave (
    input  in_valid, in_data, abort, rk_data, out_ready,
    output in_ready, rk_addr, out_valid, out_data, busy
  );
  modport master (
    output in_valid, in_data, abort, rk_data, out_ready,
    input  in_ready, rk_addr, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_inv_round_dp.sv
// One AES inverse round, purely combinational, zero latency.
// final_rnd drops InvMixColumns for the last round; no handshake.
module aes_inv_round_dp
  import aes_pkg::*;
(
  input  block_t state,
  input  block_t rk,
  input  logic   final_rnd,
  output block_t result
);
  block_t ark;

  assign ark    = inv_sub_bytes(inv_shift_rows(state)) ^ rk;
  assign result = final_rnd ? ark : inv_mix_columns(ark);
endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 decrypt sequencer: accept, 9 full rounds, final round; result 10 edges after accept.
// Result held in DONE until out_ready; in_ready follows out_ready there so blocks run back-to-back.
module aes_inv_cipher_ctrl
  import aes_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  aes_inv_cipher_ctrl_if.slave bus
);
  fsm_t     fsm_q, fsm_d;
  rk_addr_t rnd_q, rnd_d;
  block_t   st_q, st_d;
  block_t   dp_out;
  logic     final_rnd;
  logic     in_ready_c;
  rk_addr_t rk_addr_c;

  aes_inv_round_dp u_dp (
    .state     (st_q),
    .rk        (bus.rk_data),
    .final_rnd (final_rnd),
    .result    (dp_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q <= IDLE;
      rnd_q <= '0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      st_q  <= st_d;
    end
  end

  always_comb begin
    fsm_d      = fsm_q;
    rnd_d      = rnd_q;
    st_d       = st_q;
    in_ready_c = 1'b0;
    rk_addr_c  = RK_LAST;
    final_rnd  = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          st_d  = bus.in_data ^ bus.rk_data;
          rnd_d = RK_NR1;
          fsm_d = ROUND;
        end
      end
      ROUND: begin
        rk_addr_c = rnd_q;
        st_d      = dp_out;
        // Out-of-range counts cannot occur; treat them as the last full round.
        if ((rnd_q <= rk_addr_t'(1)) || (rnd_q >= RK_LAST))
          fsm_d = FINAL;
        else
          rnd_d = rnd_q - rk_addr_t'(1);
      end
      FINAL: begin
        rk_addr_c = '0;
        final_rnd = 1'b1;
        st_d      = dp_out;
        fsm_d     = DONE;
      end
      DONE: begin
        in_ready_c = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            st_d  = bus.in_data ^ bus.rk_data;
            rnd_d = RK_NR1;
            fsm_d = ROUND;
          end else begin
            fsm_d = IDLE;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
    // Flush wins over any accept or delivery on the same edge; state is left as is.
    if (bus.abort) begin
      fsm_d = IDLE;
      rnd_d = rnd_q;
      st_d  = st_q;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.rk_addr   = rk_addr_c;
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.out_data  = st_q;
  assign bus.busy      = (fsm_q == ROUND) || (fsm_q == FINAL);
endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench: FIPS-197 vectors against a bench-held key store, plus handshake corner sequences.
module tb_aes_inv_cipher_ctrl;
  logic clk;
  logic reset;
  logic ksel;
  logic [127:0] ks [2][16];
  int n_pass;
  int n_tot;

  aes_inv_cipher_ctrl_if bus ();

  aes_inv_cipher_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.rk_data = ks[ksel][bus.rk_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         kid;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  typedef struct {
    logic [3:0] rk;
    logic       busy;
    logic       inr;
    logic       ov;
  } trace_t;

  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;

  vec_t   vecs [2];
  trace_t trace [11];

  function automatic logic [127:0] mk(input logic [3:0] rk, input logic b, input logic ir, input logic ov);
    return {121'b0, rk, b, ir, ov};
  endfunction

  function automatic logic [127:0] stat();
    return {121'b0, bus.rk_addr, bus.busy, bus.in_ready, bus.out_valid};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Offer a block at a negedge; returns at the negedge after the accepting edge.
  task automatic start_blk(input logic k, input logic [127:0] ct);
    ksel = k;
    bus.in_valid = 1'b1;
    bus.in_data  = ct;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '1;
  endtask

  task automatic wait_ov(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_block(input string nm, input logic k, input logic [127:0] ct, input logic [127:0] pt);
    bus.out_ready = 1'b1;
    ksel = k;
    bus.in_valid = 1'b1;
    bus.in_data  = ct;
    #1;
    chk({nm, " accept"}, stat(), mk(4'd10, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '1;
    for (int j = 0; j < 11; j++) begin
      if (j > 0) @(negedge clk);
      chk($sformatf("%s trace%0d", nm, j), stat(), mk(trace[j].rk, trace[j].busy, trace[j].inr, trace[j].ov));
    end
    chk({nm, " data"}, bus.out_data, pt);
    @(negedge clk);
    chk({nm, " idle"}, stat(), mk(4'd10, 1'b0, 1'b1, 1'b0));
  endtask

  initial begin
    int n;
    int n2;
    logic seen;
    n_pass = 0;
    n_tot  = 0;
    for (int a = 0; a < 2; a++)
      for (int r = 0; r < 16; r++)
        ks[a][r] = '0;
    ks[0][0]  = 128'h000102030405060708090a0b0c0d0e0f;
    ks[0][1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    ks[0][2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    ks[0][3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    ks[0][4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    ks[0][5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    ks[0][6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    ks[0][7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    ks[0][8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    ks[0][9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    ks[0][10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    ks[1][0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ks[1][1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    ks[1][2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    ks[1][3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    ks[1][4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    ks[1][5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    ks[1][6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    ks[1][7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    ks[1][8]  = 128'head27321b58dbad2312bf5607f8d292f;
    ks[1][9]  = 128'hac7766f319fadc2128d12941575c006e;
    ks[1][10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    vecs[0] = '{kid: 1'b0, ct: CT_C1, pt: PT_C1};
    vecs[1] = '{kid: 1'b1, ct: 128'h3925841d02dc09fbdc118597196a0b32,
                pt: 128'h3243f6a8885a308d313198a2e0370734};

    // Expected status after each edge following the accept, out_ready held high.
    for (int j = 0; j < 9; j++) trace[j] = '{rk: 4'(9 - j), busy: 1'b1, inr: 1'b0, ov: 1'b0};
    trace[9]  = '{rk: 4'd0,  busy: 1'b1, inr: 1'b0, ov: 1'b0};
    trace[10] = '{rk: 4'd10, busy: 1'b0, inr: 1'b1, ov: 1'b1};

    ksel = 1'b0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("reset state", stat(), mk(4'd10, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 2; v++)
      do_block($sformatf("vec%0d", v), vecs[v].kid, vecs[v].ct, vecs[v].pt);

    // Backpressure: result held while out_ready is low.
    bus.out_ready = 1'b0;
    start_blk(1'b0, CT_C1);
    wait_ov(n);
    chk("bp latency", 128'(n), 128'd10);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp stat%0d", i), stat(), mk(4'd10, 1'b0, 1'b0, 1'b1));
      chk($sformatf("bp data%0d", i), bus.out_data, PT_C1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp release", stat(), mk(4'd10, 1'b0, 1'b1, 1'b1));
    @(negedge clk);
    chk("bp idle", stat(), mk(4'd10, 1'b0, 1'b1, 1'b0));

    // Back-to-back with in_valid held high.
    ksel = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = CT_C1;
    @(negedge clk);
    wait_ov(n);
    chk("b2b first lat", 128'(n), 128'd10);
    chk("b2b first data", bus.out_data, PT_C1);
    chk("b2b handoff", stat(), mk(4'd10, 1'b0, 1'b1, 1'b1));
    @(negedge clk);
    chk("b2b second accept", stat(), mk(4'd9, 1'b1, 1'b0, 1'b0));
    bus.in_valid = 1'b0;
    wait_ov(n2);
    chk("b2b gap", 128'(n2 + 1), 128'd11);
    chk("b2b second data", bus.out_data, PT_C1);
    @(negedge clk);
    chk("b2b idle", stat(), mk(4'd10, 1'b0, 1'b1, 1'b0));

    // Abort at round 5, then the same block again.
    start_blk(1'b0, CT_C1);
    repeat (4) @(negedge clk);
    chk("abort at rnd5", stat(), mk(4'd5, 1'b1, 1'b0, 1'b0));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort idle", stat(), mk(4'd10, 1'b0, 1'b1, 1'b0));
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) seen = 1'b1;
    end
    chk("abort no output", 128'(seen), 128'd0);
    do_block("post-abort", 1'b0, CT_C1, PT_C1);

    // Reset mid-block, off the clock edge.
    start_blk(1'b0, CT_C1);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst async stat", stat(), mk(4'd10, 1'b0, 1'b1, 1'b0));
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst async idle", stat(), mk(4'd10, 1'b0, 1'b1, 1'b0));
    start_blk(1'b0, CT_C1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst negedge stat", stat(), mk(4'd10, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) seen = 1'b1;
    end
    chk("rst no output", 128'(seen), 128'd0);
    do_block("post-reset", 1'b0, CT_C1, PT_C1);

    // Abort against accept in IDLE.
    bus.in_valid = 1'b1;
    bus.in_data = CT_C1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort idle no accept", stat(), mk(4'd10, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    chk("abort idle stays", stat(), mk(4'd10, 1'b0, 1'b1, 1'b0));

    // Abort against delivery and a new offer in DONE.
    bus.out_ready = 1'b0;
    start_blk(1'b0, CT_C1);
    wait_ov(n);
    chk("abort done lat", 128'(n), 128'd10);
    bus.abort = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = CT_C1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort done flush", stat(), mk(4'd10, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    chk("abort done stays", stat(), mk(4'd10, 1'b0, 1'b1, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/aes_inv_cipher_ctrl.md
Name: aes_inv_cipher_ctrl

Overview:
- Iterative AES-128 inverse-cipher sequencer.
- Owns the 128-bit state register and drives one shared inverse-round datapath (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) once per clock.
- Fetches round keys from the external key-schedule store by address.
- Accepts ciphertext blocks and returns plaintext blocks over valid/ready handshakes.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported; sizes the round counter and key address.
- RKW, 4, round-key address width; must satisfy 2**RKW > NR.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  ciphertext block offered
- in_ready  output  1  block accepted when in_valid && in_ready at a clk edge
- in_data  input  128  ciphertext; byte 0 at [127:120], column-major
- abort  input  1  synchronous flush of the block in flight
- rk_addr  output  RKW  round-key index requested this cycle
- rk_data  input  128  round key at rk_addr, combinational, same-cycle
- out_valid  output  1  plaintext block available
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_data  output  128  plaintext; same byte order as in_data
- busy  output  1  high in ROUND or FINAL

Behaviour:
- Reset values (async, immediate): FSM=IDLE, round counter=0, state register=0, out_valid=0, busy=0, in_ready=1, rk_addr=NR.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - rk_addr=NR; in_ready=1.
  - On accept: state <= in_data ^ rk_data; rnd <= NR-1; go ROUND.
- ROUND:
  - rk_addr=rnd.
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_data).
  - If rnd==1, go FINAL; else rnd <= rnd-1.
- FINAL:
  - rk_addr=0.
  - state <= InvSubBytes(InvShiftRows(state)) ^ rk_data; go DONE.
- DONE:
  - out_valid=1; out_data=state register, held stable while out_ready=0.
  - rk_addr=NR.
  - in_ready=out_ready, so a new block can be accepted on the same edge the result is taken.
  - out_ready && in_valid: load the new block and go ROUND (back-to-back; no idle bubble).
  - out_ready && !in_valid: go IDLE.
- Latency: accepting edge E0, rounds on edges E1..E9, FINAL on E10; out_valid high from E10 onward. Throughput is one block per 11 cycles.
- in_ready=0 in ROUND and FINAL; in_data is ignored there.
- out_data is undefined-but-stable outside DONE. It shows the state register; a bench checks it only when out_valid=1.
- abort:
  - Sampled in any state; next state is IDLE, out_valid drops on that edge, the state register is unchanged.
  - abort takes priority over acceptance and over out_ready in the same cycle; no block is accepted or delivered on that edge.
- reset asserted mid-block: in-flight block is discarded, no output produced, outputs take their reset values immediately.
- The round counter never wraps. Values outside 1..NR-1 in ROUND are unreachable and force FINAL defensively.

Decomposition:
- Package aes_pkg:
  - NR and RKW constants.
  - FSM state enum (IDLE, ROUND, FINAL, DONE).
  - 128-bit block typedef and round-key address typedef.
- Sub-module aes_inv_round_dp (combinational): inputs state, rk, final_rnd.
  - Output = final_rnd ? ISB(ISR(s))^rk : IMC(ISB(ISR(s))^rk).
  - Instantiates the existing InvShiftRows, InvSubBytes, InvMixColumns blocks.
- aes_inv_cipher_ctrl keeps only the FSM, counter, state register and handshake logic.

Test Plan:
- FIPS-197 C.1 block:
  - Stimulus: key store loaded from key 000102030405060708090a0b0c0d0e0f (rk[10]=13111d7fe3944a17f307a78b4d2b30c5); in_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1.
  - Required: out_data=00112233445566778899aabbccddeeff; out_valid rises exactly 10 edges after accept; rk_addr sequence 10,9,...,1,0.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after out_valid.
  - Required: out_valid and out_data stay stable; in_ready=0 throughout; completes on the first out_ready=1.
- Back-to-back:
  - Stimulus: two C.1 blocks with in_valid held high and out_ready=1.
  - Required: second block accepted on the edge the first is delivered; second out_valid exactly 11 cycles after the first.
- Abort:
  - Stimulus: abort at round 5; then the C.1 block issued again.
  - Required: FSM returns to IDLE, no out_valid; the next block decrypts correctly.
- Reset mid-block:
  - Stimulus: reset pulse during ROUND, including one not aligned to clk.
  - Required: out_valid=0, busy=0, in_ready=1 and rk_addr=10 immediately, without waiting for a clock edge.
- Abort vs. handshake:
  - Stimulus: abort with in_valid=1 in IDLE; then abort with out_ready=1 in DONE.
  - Required: no accept and no delivery in either case; busy stays 0 afterwards.
